// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Moore control FSM that fetches and sequences ALU, MUL/DIV, NOP
//               and HALT instructions, driving datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] R0_15_in,
    output logic [15:0] R0_15_out,
    output logic [4:0]  opcode,
    output logic        halted,
    output logic        illegal
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu3;
    logic       is_muldiv;
    logic       is_nop;
    logic       is_haltop;
    logic       is_illegal;
    logic       ready;
    logic [3:0] instr_end;
    logic       unused_ir;

    assign op         = ir[31:27];
    assign ra         = ir[26:23];
    assign rb         = ir[22:19];
    assign rc         = ir[18:15];
    assign unused_ir  = ^ir[14:0];

    assign is_alu3    = (op <= 5'b01010);
    assign is_muldiv  = (op == 5'b01111) || (op == 5'b10000);
    assign is_nop     = (op == 5'b11010);
    assign is_haltop  = (op == 5'b11011);
    assign is_illegal = !(is_alu3 || is_muldiv || is_nop || is_haltop);

    assign ready      = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
    // A dropped run lets the current instruction finish, then parks in IDLE.
    assign instr_end  = run ? S_T0 : S_IDLE;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_T3 && is_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: next_state = run ? S_T0 : S_IDLE;
            S_T0:   next_state = S_T1;
            S_T1:   next_state = ready ? S_T2 : S_T1;
            S_T2:   next_state = S_T3;
            S_T3: begin
                if (is_nop)                       next_state = instr_end;
                else if (is_haltop || is_illegal) next_state = S_HALT;
                else                              next_state = S_T4;
            end
            S_T4:   next_state = S_T5;
            S_T5:   next_state = is_muldiv ? S_T6 : instr_end;
            S_T6:   next_state = instr_end;
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        Zhighin   = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        R0_15_in  = 16'd0;
        R0_15_out = 16'd0;
        opcode    = 5'd0;
        halted    = 1'b0;
        case (state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                // PC and MDR load only on the exit cycle so a stall loads PC once.
                Zlowout = 1'b1;
                Read    = 1'b1;
                PCin    = ready;
                MDRin   = ready;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu3) begin
                    R0_15_out = 16'd1 << rb;
                    Yin       = 1'b1;
                end else if (is_muldiv) begin
                    R0_15_out = 16'd1 << ra;
                    Yin       = 1'b1;
                end
            end
            S_T4: begin
                opcode = op;
                Zlowin = 1'b1;
                if (is_muldiv) begin
                    R0_15_out = 16'd1 << rb;
                    Zhighin   = 1'b1;
                end else begin
                    R0_15_out = 16'd1 << rc;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) LOin     = 1'b1;
                else           R0_15_in = 16'd1 << ra;
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Scoreboard bench for control_sequencer directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    typedef struct packed {
        logic        pc_out, zlo_out, zhi_out, mdr_out;
        logic        mar_in, pc_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, hi_in, lo_in;
        logic        inc_pc, read;
        logic [15:0] r_in, r_out;
        logic [4:0]  opc;
        logic        halted, illegal;
    } out_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_ready = 1'b1;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin;
    logic        IncPC, Read;
    logic [15:0] R0_15_in, R0_15_out;
    logic [4:0]  opcode;
    logic        halted, illegal;

    int          n_compared = 0;
    int          n_mismatched = 0;
    string       sb_tag[$];
    out_t        sb_exp[$];
    string       mon_tag;
    out_t        mon_exp;

    control_sequencer #(.MEM_WAIT_EN(1)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .R0_15_in(R0_15_in), .R0_15_out(R0_15_out),
        .opcode(opcode), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic out_t sample();
        return {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                Zlowin, Zhighin, HIin, LOin, IncPC, Read, R0_15_in, R0_15_out,
                opcode, halted, illegal};
    endfunction

    function automatic out_t e_t0();
        out_t e = '0;
        e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.zlo_in = 1'b1;
        return e;
    endfunction

    function automatic out_t e_t1(input logic rdy);
        out_t e = '0;
        e.zlo_out = 1'b1; e.read = 1'b1; e.pc_in = rdy; e.mdr_in = rdy;
        return e;
    endfunction

    function automatic out_t e_t2();
        out_t e = '0;
        e.mdr_out = 1'b1; e.ir_in = 1'b1;
        return e;
    endfunction

    function automatic out_t e_t3(input int r);
        out_t e = '0;
        e.r_out = 16'd1 << r; e.y_in = 1'b1;
        return e;
    endfunction

    function automatic out_t e_t4(input int r, input logic [4:0] op, input logic md);
        out_t e = '0;
        e.r_out = 16'd1 << r; e.zlo_in = 1'b1; e.zhi_in = md; e.opc = op;
        return e;
    endfunction

    function automatic out_t e_t5_alu(input int r);
        out_t e = '0;
        e.zlo_out = 1'b1; e.r_in = 16'd1 << r;
        return e;
    endfunction

    function automatic out_t e_t5_mul();
        out_t e = '0;
        e.zlo_out = 1'b1; e.lo_in = 1'b1;
        return e;
    endfunction

    function automatic out_t e_t6();
        out_t e = '0;
        e.zhi_out = 1'b1; e.hi_in = 1'b1;
        return e;
    endfunction

    function automatic out_t e_halt(input logic ill);
        out_t e = '0;
        e.halted = 1'b1; e.illegal = ill;
        return e;
    endfunction

    // Expectation for the cycle now in progress; the monitor pops it at negedge.
    task automatic cyc(input string tag, input out_t e);
        sb_tag.push_back(tag);
        sb_exp.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input int stall);
        cyc("T0", e_t0());
        mem_ready = 1'b0;
        for (int i = 0; i < stall; i++) cyc("T1_wait", e_t1(1'b0));
        mem_ready = 1'b1;
        cyc("T1", e_t1(1'b1));
        cyc("T2", e_t2());
    endtask

    task automatic pulse_clear(input string tag);
        #2;
        clear = 1'b0;
        #1;
        check_value(tag, 64'(sample()), 64'd0);
        sb_tag.push_back("in_clear");
        sb_exp.push_back('0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        cyc("IDLE_after_clear", '0);
    endtask

    always @(negedge clock) begin
        if (sb_exp.size() != 0) begin
            mon_tag = sb_tag.pop_front();
            mon_exp = sb_exp.pop_front();
            check_value(mon_tag, 64'(sample()), 64'(mon_exp));
        end
        check_value("bus_onehot", 64'($countones({PCout, Zlowout, Zhighout, MDRout}) <= 1), 64'd1);
        check_value("rout_onehot", 64'($countones(R0_15_out) <= 1), 64'd1);
        check_value("rin_onehot", 64'($countones(R0_15_in) <= 1), 64'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        check_value("reset_now", 64'(sample()), 64'd0);
        cyc("reset", '0);
        cyc("reset", '0);
        clear = 1'b1;
        cyc("IDLE_run0", '0);
        run = 1'b1;
        cyc("IDLE_run1", '0);

        // add r1, r2, r3
        ir = 32'h1891_8000;
        fetch(0);
        cyc("add_T3", e_t3(2));
        cyc("add_T4", e_t4(3, 5'b00011, 1'b0));
        cyc("add_T5", e_t5_alu(1));

        // nop with three stall cycles in T1
        ir = 32'hD000_0000;
        fetch(3);
        cyc("nop_T3", '0);

        // mul r4, r5 with run dropped mid-instruction
        ir = 32'h7A28_0000;
        fetch(0);
        cyc("mul_T3", e_t3(4));
        run = 1'b0;
        cyc("mul_T4", e_t4(5, 5'b01111, 1'b1));
        cyc("mul_T5", e_t5_mul());
        cyc("mul_T6", e_t6());
        cyc("IDLE_after_stop", '0);
        run = 1'b1;
        cyc("IDLE_resume", '0);

        // halt opcode
        ir = 32'hD800_0000;
        fetch(0);
        cyc("halt_T3", '0);
        cyc("HALT", e_halt(1'b0));
        run = 1'b0;
        cyc("HALT_run0", e_halt(1'b0));
        run = 1'b1;
        pulse_clear("clear_halt");

        // illegal opcode
        ir = 32'hF800_0000;
        fetch(0);
        cyc("ill_T3", '0);
        cyc("HALT_ill", e_halt(1'b1));
        run = 1'b0;
        cyc("HALT_ill_run0", e_halt(1'b1));
        run = 1'b1;
        cyc("HALT_ill_run1", e_halt(1'b1));
        pulse_clear("clear_illegal");

        // clear pulsed during T4 of an add, then restart and finish with run low
        ir = 32'h1891_8000;
        fetch(0);
        cyc("add2_T3", e_t3(2));
        pulse_clear("clear_T4");
        cyc("T0_restart", e_t0());
        run = 1'b0;
        cyc("T1_restart", e_t1(1'b1));
        cyc("T2_restart", e_t2());
        cyc("add3_T3", e_t3(2));
        cyc("add3_T4", e_t4(3, 5'b00011, 1'b0));
        cyc("add3_T5", e_t5_alu(1));
        cyc("IDLE_end", '0);
        cyc("IDLE_end", '0);

        check_value("sb_drained", 64'(sb_exp.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_EN, default 1, meaning 1 = T1 stalls on mem_ready and 0 = mem_ready is ignored (treated as 1).
REQ-002 The block SHALL have these ports:
- clock  in  1  sole clock; rising-edge.
- clear  in  1  reset; asynchronous, active-low.
- run  in  1  start/resume; level.
- ir  in  32  instruction register contents from the datapath.
- mem_ready  in  1  memory data valid.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus-drive strobes.
- MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin  out  1 each  register-load strobes.
- IncPC, Read  out  1 each  PC increment and memory read.
- R0_15_in  out  16  one-hot register-file load.
- R0_15_out  out  16  one-hot register-file drive.
- opcode  out  5  ALU operation select.
- halted  out  1  sequencer stopped.
- illegal  out  1  stop caused by an undefined opcode.

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; every output SHALL depend only on the current state and ir.
REQ-004 Field decode SHALL be: op = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
REQ-005 Opcode classes SHALL be:
- ALU3: 00000-01010 (add, sub, and, or, shr, shra, shl, ror, rol, neg, not).
- MULDIV: 01111 (mul), 10000 (div).
- NOP: 11010.
- HALTOP: 11011.
- All other values: illegal.
REQ-006 IDLE SHALL assert no strobes and go to T0 on the first edge where run = 1.
REQ-007 T0 SHALL assert PCout, MARin, IncPC, Zlowin, then go to T1.
REQ-008 T1 SHALL assert Zlowout, PCin, Read.
- MDRin SHALL be asserted only while mem_ready = 1.
- T1 SHALL stay in T1 while mem_ready = 0 and go to T2 on the first edge with mem_ready = 1.
- PCin SHALL be asserted only in the exit cycle, so PC is loaded exactly once.
REQ-009 T2 SHALL assert MDRout, IRin, then go to T3.
REQ-010 In T3, by class:
- NOP: no strobes, next state T0.
- HALTOP: no strobes, next state HALT.
- Illegal: no strobes, next state HALT with illegal set.
- ALU3: R0_15_out[rb] and Yin.
- MULDIV: R0_15_out[ra] and Yin.
REQ-011 In T4, opcode SHALL equal op, and:
- ALU3 SHALL assert R0_15_out[rc] and Zlowin.
- MULDIV SHALL assert R0_15_out[rb], Zlowin, Zhighin.
- opcode SHALL be 00000 in every state other than T4.
REQ-012 T5 SHALL assert Zlowout plus either R0_15_in[ra] (ALU3, next state T0) or LOin (MULDIV, next state T6).
REQ-013 T6 SHALL assert Zhighout and HIin, then go to T0.
REQ-014 At most one of PCout, Zlowout, Zhighout, MDRout, and at most one bit of R0_15_out, SHALL be high in any cycle.
REQ-015 R0_15_in and R0_15_out SHALL be all-zero outside the states listed above, and SHALL be one-hot when active.
REQ-016 HALT SHALL assert halted and hold, ignoring run, until clear.
REQ-017 illegal SHALL be set on entry to HALT from an illegal opcode, and cleared only by clear.
REQ-018 If run falls during T0-T6, the current instruction SHALL complete; the FSM SHALL return to IDLE instead of T0 when run = 0 at instruction end.
REQ-019 ir SHALL be sampled combinationally; the datapath holds ir stable from T3 to the end of the instruction.

Reset
REQ-020 While clear = 0, the block SHALL immediately force:
- state IDLE;
- all strobes, R0_15_in, R0_15_out, opcode, halted, illegal to 0.
REQ-021 Deassertion of clear SHALL take effect at the next rising clock edge; reset mid-instruction SHALL abandon the instruction with no further strobes.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add: ir=0x18918000 (op 00011, ra=1, rb=2, rc=3), mem_ready=1, run=1 -> T3 R0_15_out=0x0004 with Yin; T4 R0_15_out=0x0008, opcode=00011, Zlowin; T5 R0_15_in=0x0002, Zlowout; 6 cycles per instruction.
- Memory stall: mem_ready low for 3 cycles in T1 -> FSM holds T1 for 4 cycles, MDRin high only in the last, PCin high exactly 1 cycle.
- mul: ir=op 01111, ra=4, rb=5 -> T5 LOin, T6 HIin with Zhighout, 7 cycles total, R0_15_in stays 0.
- ir op=11111 -> HALT with halted=1 and illegal=1 after T3; run toggling has no effect; clear low -> both flags 0 asynchronously.
- clear pulsed low during T4 -> all outputs 0 at once; after release the FSM restarts at IDLE then T0.
- Every cycle of every test: bus-drive outputs and R0_15_out at most one-hot.
